// File: rtl/ifu_fd_stage_pkg.sv
// Shared constants and types for the fetch / F-D pipeline stage.
// Imported by ifu_fd_stage.
package ifu_fd_stage_pkg;

    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        IFU_FETCH = 1'b0,
        IFU_HELD  = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } fd_reg_t;

endpackage

// File: rtl/ifu_fd_stage.sv
// Fetch stage: owns F_PC, talks to a variable-latency imem over req/ready,
// and holds the F/D pipeline register with a one-entry park buffer.
module ifu_fd_stage
    import ifu_fd_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic        fetch_busy
);

    ifu_state_e  state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    fd_reg_t     fd_q, fd_d;

    logic in_fetch;
    logic fetch_adv;
    logic fetch_park;
    logic held_adv;

    assign in_fetch   = (state_q == IFU_FETCH);
    assign fetch_adv  = in_fetch & imem_ready & ~stall_d;
    assign fetch_park = in_fetch & imem_ready & stall_d;
    assign held_adv   = ~in_fetch & ~stall_d;

    always_comb begin
        state_d      = state_q;
        f_pc_d       = f_pc_q;
        hold_instr_d = hold_instr_q;
        fd_d         = fd_q;
        unique case (1'b1)
            fetch_adv: begin
                fd_d   = '{pc: f_pc_q, instr: imem_rdata, valid: 1'b1};
                f_pc_d = npc;
            end
            fetch_park: begin
                hold_instr_d = imem_rdata;
                state_d      = IFU_HELD;
            end
            held_adv: begin
                fd_d    = '{pc: f_pc_q, instr: hold_instr_q, valid: 1'b1};
                f_pc_d  = npc;
                state_d = IFU_FETCH;
            end
            default: ;
        endcase
    end

    // Reset also drops imem_req, so an in-flight response is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IFU_FETCH;
            f_pc_q       <= RESET_PC;
            hold_instr_q <= '0;
            fd_q         <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            hold_instr_q <= hold_instr_d;
            fd_q         <= fd_d;
        end
    end

    assign imem_req   = in_fetch & ~reset;
    assign imem_addr  = f_pc_q;
    assign f_pc       = f_pc_q;
    assign d_pc       = fd_q.pc;
    assign d_instr    = fd_q.instr;
    assign d_valid    = fd_q.valid;
    assign fetch_busy = in_fetch & ~imem_ready;

endmodule

// File: tb/tb_ifu_fd_stage.sv
// Bench for ifu_fd_stage: directed plan scenarios plus a randomized run
// against a capture-then-drain reference model.
module tb_ifu_fd_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] npc = '0;
    logic        stall_d = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        fetch_busy;

    int vec = 0;
    int err = 0;

    // Reference model: the fetched-but-not-consumed word lives in a queue.
    logic [31:0] m_fpc;
    logic [31:0] m_dpc;
    logic [31:0] m_dinstr;
    logic        m_dvalid;
    logic [31:0] m_buf[$];

    always #5 clk = ~clk;

    ifu_fd_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall_d    (stall_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .f_pc       (f_pc),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_valid    (d_valid),
        .fetch_busy (fetch_busy)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic m_req();
        return (m_buf.size() == 0) && !reset;
    endfunction

    task automatic apply(input logic r, input logic st, input logic rdy,
                         input logic [31:0] np, input logic [31:0] rd);
        reset      = r;
        stall_d    = st;
        imem_ready = rdy;
        npc        = np;
        imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_fpc    = 32'h0000_3000;
            m_dpc    = 32'h0;
            m_dinstr = 32'h0;
            m_dvalid = 1'b0;
            m_buf.delete();
        end else begin
            if (m_buf.size() == 0 && imem_ready) m_buf.push_back(imem_rdata);
            if (m_buf.size() != 0 && !stall_d) begin
                m_dpc    = m_fpc;
                m_dinstr = m_buf.pop_front();
                m_dvalid = 1'b1;
                m_fpc    = npc;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (f_pc !== 32'h3000) begin err++; $display("FAIL reset_fpc got=%h exp=3000", f_pc); end
        vec++; if (d_pc !== 32'h0) begin err++; $display("FAIL reset_dpc got=%h exp=0", d_pc); end
        vec++; if (d_instr !== 32'h0) begin err++; $display("FAIL reset_dinstr got=%h exp=0", d_instr); end
        vec++; if (d_valid !== 1'b0) begin err++; $display("FAIL reset_dvalid got=%b exp=0", d_valid); end
        vec++; if (imem_req !== 1'b1) begin err++; $display("FAIL reset_req_after got=%b exp=1", imem_req); end
        vec++; if (fetch_busy !== 1'b1) begin err++; $display("FAIL reset_busy got=%b exp=1", fetch_busy); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + 32'(4 * i);
            apply(1'b0, 1'b0, 1'b1, a + 32'h4, w(a));
            vec++; if (imem_addr !== a) begin err++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, a); end
            if (i == 0) begin
                vec++; if (d_valid !== 1'b0) begin err++; $display("FAIL zw_dvalid0 got=%b exp=0", d_valid); end
            end else begin
                vec++; if (d_valid !== 1'b1) begin err++; $display("FAIL zw_dvalid[%0d] got=%b exp=1", i, d_valid); end
                vec++; if (d_pc !== a - 32'h4) begin err++; $display("FAIL zw_dpc[%0d] got=%h exp=%h", i, d_pc, a - 32'h4); end
                vec++; if (d_instr !== w(a - 32'h4)) begin err++; $display("FAIL zw_dinstr[%0d] got=%h exp=%h", i, d_instr, w(a - 32'h4)); end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'hBAD0_0000, 32'h0);
            vec++; if (fetch_busy !== 1'b1) begin err++; $display("FAIL lat_busy[%0d] got=%b exp=1", i, fetch_busy); end
            vec++; if (d_valid !== 1'b0) begin err++; $display("FAIL lat_dvalid[%0d] got=%b exp=0", i, d_valid); end
            tick();
        end
        apply(1'b0, 1'b0, 1'b1, 32'h3100, w(32'h3000));
        vec++; if (fetch_busy !== 1'b0) begin err++; $display("FAIL lat_busy_rdy got=%b exp=0", fetch_busy); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (d_pc !== 32'h3000) begin err++; $display("FAIL lat_dpc got=%h exp=3000", d_pc); end
        vec++; if (d_instr !== w(32'h3000)) begin err++; $display("FAIL lat_dinstr got=%h exp=%h", d_instr, w(32'h3000)); end
        vec++; if (f_pc !== 32'h3100) begin err++; $display("FAIL lat_fpc got=%h exp=3100", f_pc); end
    endtask

    task automatic test_stall_on_ready();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 32'h2402_0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'hDEAD_0004, 32'hFFFF_FFFF);
            vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL held_req[%0d] got=%b exp=0", i, imem_req); end
            vec++; if (fetch_busy !== 1'b0) begin err++; $display("FAIL held_busy[%0d] got=%b exp=0", i, fetch_busy); end
            vec++; if (f_pc !== 32'h3000) begin err++; $display("FAIL held_fpc[%0d] got=%h exp=3000", i, f_pc); end
            vec++; if (d_valid !== 1'b0) begin err++; $display("FAIL held_dvalid[%0d] got=%b exp=0", i, d_valid); end
            if (i == 0) tick();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h3040, 32'hFFFF_FFFF);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (d_instr !== 32'h2402_0001) begin err++; $display("FAIL rel_dinstr got=%h exp=24020001", d_instr); end
        vec++; if (d_pc !== 32'h3000) begin err++; $display("FAIL rel_dpc got=%h exp=3000", d_pc); end
        vec++; if (imem_req !== 1'b1) begin err++; $display("FAIL rel_req got=%b exp=1", imem_req); end
        vec++; if (imem_addr !== 32'h3040) begin err++; $display("FAIL rel_addr got=%h exp=3040", imem_addr); end
    endtask

    task automatic test_branch_wait();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = 32'h3000 + 32'(4 * i);
            apply(1'b0, 1'b0, 1'b1, a + 32'h4, w(a));
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h3020, 32'h0);
        vec++; if (d_pc !== 32'h3008) begin err++; $display("FAIL br_dpc_wait got=%h exp=3008", d_pc); end
        vec++; if (fetch_busy !== 1'b1) begin err++; $display("FAIL br_busy got=%b exp=1", fetch_busy); end
        vec++; if (imem_addr !== 32'h300C) begin err++; $display("FAIL br_addr got=%h exp=300c", imem_addr); end
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h3020, w(32'h300C));
        vec++; if (d_pc !== 32'h3008) begin err++; $display("FAIL br_dpc_hold got=%h exp=3008", d_pc); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (d_pc !== 32'h300C) begin err++; $display("FAIL br_dpc_ds got=%h exp=300c", d_pc); end
        vec++; if (d_instr !== w(32'h300C)) begin err++; $display("FAIL br_dinstr got=%h exp=%h", d_instr, w(32'h300C)); end
        vec++; if (f_pc !== 32'h3020) begin err++; $display("FAIL br_fpc got=%h exp=3020", f_pc); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        apply(1'b0, 1'b0, 1'b1, 32'h3004, w(32'h3000));
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'h7777_0000, 32'hDEAD_BEEF);
        vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL rmw_req got=%b exp=0", imem_req); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (f_pc !== 32'h3000) begin err++; $display("FAIL rmw_fpc got=%h exp=3000", f_pc); end
        vec++; if (d_valid !== 1'b0) begin err++; $display("FAIL rmw_dvalid got=%b exp=0", d_valid); end
        vec++; if (d_instr !== 32'h0) begin err++; $display("FAIL rmw_dinstr got=%h exp=0", d_instr); end
    endtask

    task automatic test_reset_held();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (imem_req !== 1'b1) begin err++; $display("FAIL rh_req got=%b exp=1", imem_req); end
        apply(1'b0, 1'b0, 1'b1, 32'h3004, w(32'h3000));
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++; if (d_instr !== w(32'h3000)) begin err++; $display("FAIL rh_dinstr got=%h exp=%h", d_instr, w(32'h3000)); end
        vec++; if (d_pc !== 32'h3000) begin err++; $display("FAIL rh_dpc got=%h exp=3000", d_pc); end
    endtask

    task automatic test_random();
        int          lat;
        logic        r, st, rdy;
        logic [31:0] np, rd;
        bit          was_req;
        do_reset();
        lat = int'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 2) == 0);
            np  = ($urandom_range(0, 3) == 0) ? $urandom : m_fpc + 32'h4;
            rd  = ($urandom_range(0, 7) == 0) ? $urandom : w(m_fpc);
            was_req = (m_buf.size() == 0) && !r;
            rdy = was_req && (lat == 0);
            apply(r, st, rdy, np, rd);
            vec++; if (imem_req !== m_req()) begin err++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, imem_req, m_req()); end
            vec++; if (imem_addr !== m_fpc) begin err++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, imem_addr, m_fpc); end
            vec++; if (f_pc !== m_fpc) begin err++; $display("FAIL rnd_fpc[%0d] got=%h exp=%h", i, f_pc, m_fpc); end
            vec++; if (d_pc !== m_dpc) begin err++; $display("FAIL rnd_dpc[%0d] got=%h exp=%h", i, d_pc, m_dpc); end
            vec++; if (d_instr !== m_dinstr) begin err++; $display("FAIL rnd_dinstr[%0d] got=%h exp=%h", i, d_instr, m_dinstr); end
            vec++; if (d_valid !== m_dvalid) begin err++; $display("FAIL rnd_dvalid[%0d] got=%b exp=%b", i, d_valid, m_dvalid); end
            vec++; if (fetch_busy !== ((m_buf.size() == 0) && !rdy)) begin
                err++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, fetch_busy, (m_buf.size() == 0) && !rdy);
            end
            tick();
            if (r || rdy) lat = int'($urandom_range(0, 3));
            else if (was_req && lat > 0) lat--;
        end
    endtask

    initial begin
        m_fpc    = 32'h3000;
        m_dpc    = 32'h0;
        m_dinstr = 32'h0;
        m_dvalid = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_on_ready();
        test_branch_wait();
        test_reset_mid_wait();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
